m6502_bus_arbiter: RTL

Shares one single-port memory bus between the m6502 CPU and two DMA masters (DMA0 = video fetch, DMA1 = blitter/audio). Each master sees the same pulse-request/ready-level bus protocol the CPU core already drives. The arbiter latches requests, grants one outstanding memory access at a time, and returns read data and ready per port. It sits between the CPU/DMA masters and the system RAM/ROM decoder.

---
 rtl/m6502_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/m6502_bus_arbiter.sv
// Shares one single-port memory bus between the 6502 CPU and two DMA masters (video, blitter/audio).
// Optional round-robin grant order is enabled by defining M6502_BUS_ARB_RR_EN.
module m6502_bus_arbiter #(
  parameter int CPU_MAX_SKIP   = 4,
  parameter bit DMA0_OVER_DMA1 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd_req,
  input  logic        cpu_wr_en,
  input  logic [7:0]  cpu_wr_data,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_ready,
  input  logic [15:0] dma0_addr,
  input  logic        dma0_rd_req,
  input  logic        dma0_wr_en,
  input  logic [7:0]  dma0_wr_data,
  output logic [7:0]  dma0_rd_data,
  output logic        dma0_ready,
  input  logic [15:0] dma1_addr,
  input  logic        dma1_rd_req,
  input  logic        dma1_wr_en,
  input  logic [7:0]  dma1_wr_data,
  output logic [7:0]  dma1_rd_data,
  output logic        dma1_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wr_data,
  output logic        mem_rd_req,
  output logic        mem_wr_en,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_ready,
  output logic [1:0]  bus_owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;

  state_t      state_r, state_nxt_s;
  logic [2:0]  req_s;
  logic [2:0]  wr_req_s;
  logic [15:0] addr_in_s [3];
  logic [7:0]  wdata_in_s [3];
  logic [2:0]  pend_r;
  logic [2:0]  wr_kind_r;
  logic [15:0] addr_r [3];
  logic [7:0]  wdata_r [3];

  logic [1:0]  win_idx_s;
  logic [15:0] win_addr_s;
  logic [7:0]  win_wdata_s;
  logic        win_wr_s;
  logic [1:0]  cur_idx_s;
  logic        cur_wr_s;
  logic        grant_s;
  logic        done_s;

  logic [15:0] mem_addr_r, mem_addr_nxt_s;
  logic [7:0]  mem_wdata_r, mem_wdata_nxt_s;
  logic        mem_rd_req_r, mem_rd_req_nxt_s;
  logic        mem_wr_en_r, mem_wr_en_nxt_s;
  logic [1:0]  bus_owner_r, bus_owner_nxt_s;
  logic [7:0]  rd_data_r [3];

  // Index 0 = CPU, 1 = DMA0, 2 = DMA1; owner code is index + 1.
  assign req_s         = {dma1_rd_req | dma1_wr_en, dma0_rd_req | dma0_wr_en, cpu_rd_req | cpu_wr_en};
  assign wr_req_s      = {dma1_wr_en, dma0_wr_en, cpu_wr_en};
  assign addr_in_s[0]  = cpu_addr;
  assign addr_in_s[1]  = dma0_addr;
  assign addr_in_s[2]  = dma1_addr;
  assign wdata_in_s[0] = cpu_wr_data;
  assign wdata_in_s[1] = dma0_wr_data;
  assign wdata_in_s[2] = dma1_wr_data;

  // Per-port request latch: capture when idle, release on completion of that port's access.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r    <= 3'b000;
      wr_kind_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        addr_r[i]  <= 16'h0000;
        wdata_r[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (req_s[i] && !pend_r[i]) begin
          pend_r[i]    <= 1'b1;
          wr_kind_r[i] <= wr_req_s[i];
          addr_r[i]    <= addr_in_s[i];
          wdata_r[i]   <= wdata_in_s[i];
        end else if (done_s && (cur_idx_s == 2'(i))) begin
          pend_r[i] <= 1'b0;
        end
      end
    end
  end

`ifdef M6502_BUS_ARB_RR_EN
  logic [1:0] last_r;

  // Next pending port after the last owner, wrapping CPU -> DMA0 -> DMA1.
  function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
    logic [1:0] c1;
    logic [1:0] c2;
    case (last)
      2'd0:    begin c1 = 2'd1; c2 = 2'd2; end
      2'd1:    begin c1 = 2'd2; c2 = 2'd0; end
      default: begin c1 = 2'd0; c2 = 2'd1; end
    endcase
    if (pend[c1]) begin
      return c1;
    end else if (pend[c2]) begin
      return c2;
    end else begin
      return last;
    end
  endfunction

  // Round-robin winner selection.
  always_comb begin
    win_idx_s = rr_pick(pend_r, last_r);
  end

  // Last owner; reset value makes the CPU first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= 2'd2;
    end else if (grant_s) begin
      last_r <= win_idx_s;
    end else begin
      last_r <= last_r;
    end
  end
`else
  localparam bit         GUARD_EN = (CPU_MAX_SKIP != 0);
  localparam logic [2:0] MAX_SKIP = 3'(CPU_MAX_SKIP);

  logic [2:0] skip_r;

  // Fixed DMA priority, overridden when the CPU has been passed over too often.
  always_comb begin
    win_idx_s = 2'd0;
    if (GUARD_EN && pend_r[0] && (skip_r == MAX_SKIP)) begin
      win_idx_s = 2'd0;
    end else if (DMA0_OVER_DMA1) begin
      if (pend_r[1])      win_idx_s = 2'd1;
      else if (pend_r[2]) win_idx_s = 2'd2;
      else                win_idx_s = 2'd0;
    end else begin
      if (pend_r[2])      win_idx_s = 2'd2;
      else if (pend_r[1]) win_idx_s = 2'd1;
      else                win_idx_s = 2'd0;
    end
  end

  // Saturating count of DMA grants taken while the CPU was waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_r <= 3'd0;
    end else if (!pend_r[0]) begin
      skip_r <= 3'd0;
    end else if (grant_s) begin
      if (win_idx_s == 2'd0)    skip_r <= 3'd0;
      else if (skip_r != 3'd7)  skip_r <= skip_r + 3'd1;
      else                      skip_r <= skip_r;
    end else begin
      skip_r <= skip_r;
    end
  end
`endif

  // Latched request fields of the winner and of the current owner.
  always_comb begin
    win_addr_s  = addr_r[0];
    win_wdata_s = wdata_r[0];
    win_wr_s    = wr_kind_r[0];
    case (win_idx_s)
      2'd1:    begin win_addr_s = addr_r[1]; win_wdata_s = wdata_r[1]; win_wr_s = wr_kind_r[1]; end
      2'd2:    begin win_addr_s = addr_r[2]; win_wdata_s = wdata_r[2]; win_wr_s = wr_kind_r[2]; end
      default: begin win_addr_s = addr_r[0]; win_wdata_s = wdata_r[0]; win_wr_s = wr_kind_r[0]; end
    endcase
    cur_idx_s = bus_owner_r - 2'd1;
    case (cur_idx_s)
      2'd1:    cur_wr_s = wr_kind_r[1];
      2'd2:    cur_wr_s = wr_kind_r[2];
      default: cur_wr_s = wr_kind_r[0];
    endcase
  end

  // Arbiter next-state and next bus outputs.
  always_comb begin
    state_nxt_s      = state_r;
    mem_addr_nxt_s   = mem_addr_r;
    mem_wdata_nxt_s  = mem_wdata_r;
    mem_rd_req_nxt_s = 1'b0;
    mem_wr_en_nxt_s  = 1'b0;
    bus_owner_nxt_s  = bus_owner_r;
    grant_s          = 1'b0;
    done_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (|pend_r) begin
          grant_s          = 1'b1;
          mem_addr_nxt_s   = win_addr_s;
          mem_wdata_nxt_s  = win_wdata_s;
          mem_rd_req_nxt_s = ~win_wr_s;
          mem_wr_en_nxt_s  = win_wr_s;
          bus_owner_nxt_s  = win_idx_s + 2'd1;
          state_nxt_s      = ISSUE;
        end else begin
          bus_owner_nxt_s  = OWN_NONE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        // Strobes are already low here, so only a post-issue ready completes.
        if (mem_ready) begin
          done_s          = 1'b1;
          bus_owner_nxt_s = OWN_NONE;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s     = WAIT;
        end
      end
      default: begin
        bus_owner_nxt_s = OWN_NONE;
        state_nxt_s     = IDLE;
      end
    endcase
  end

  // FSM state and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      mem_addr_r   <= 16'h0000;
      mem_wdata_r  <= 8'h00;
      mem_rd_req_r <= 1'b0;
      mem_wr_en_r  <= 1'b0;
      bus_owner_r  <= OWN_NONE;
    end else begin
      state_r      <= state_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_wdata_r  <= mem_wdata_nxt_s;
      mem_rd_req_r <= mem_rd_req_nxt_s;
      mem_wr_en_r  <= mem_wr_en_nxt_s;
      bus_owner_r  <= bus_owner_nxt_s;
    end
  end

  // Read data returned to the owning port on read completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) rd_data_r[i] <= 8'h00;
    end else if (done_s && !cur_wr_s) begin
      case (cur_idx_s)
        2'd1:    rd_data_r[1] <= mem_rd_data;
        2'd2:    rd_data_r[2] <= mem_rd_data;
        default: rd_data_r[0] <= mem_rd_data;
      endcase
    end else begin
      for (int i = 0; i < 3; i++) rd_data_r[i] <= rd_data_r[i];
    end
  end

  assign mem_addr     = mem_addr_r;
  assign mem_wr_data  = mem_wdata_r;
  assign mem_rd_req   = mem_rd_req_r;
  assign mem_wr_en    = mem_wr_en_r;
  assign bus_owner    = bus_owner_r;
  assign cpu_rd_data  = rd_data_r[0];
  assign dma0_rd_data = rd_data_r[1];
  assign dma1_rd_data = rd_data_r[2];
  assign cpu_ready    = ~pend_r[0];
  assign dma0_ready   = ~pend_r[1];
  assign dma1_ready   = ~pend_r[2];

endmodule
